// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the fetch address and queues
// {pc, instr} pairs for decode; a misaligned redirect parks it in FAULT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    logic [31:0] ent_pc_q    [DEPTH];
    logic [31:0] ent_instr_q [DEPTH];

    logic running;
    logic pop;
    logic push;
    logic flush;
    logic redirect_ok;

    assign running     = (state_q == ST_RUN);
    assign out_valid   = running && (count_q != '0);
    assign pop         = out_valid & out_ready & ~redirect_valid;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign push        = running & ~redirect_valid & ((count_q < FULL_CNT) | pop);
    assign flush       = running & redirect_valid;
    assign redirect_ok = (redirect_pc[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            if (redirect_ok) begin
                pc_d = redirect_pc;
            end else begin
                state_d = ST_FAULT;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Entries are cleared on reset so the head reads as zero right after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ent_pc_q[gi]    <= '0;
                    ent_instr_q[gi] <= '0;
                end else if (push && (tail_q == AW'(gi))) begin
                    ent_pc_q[gi]    <= pc_q;
                    ent_instr_q[gi] <= idata;
                end
            end
        end
    endgenerate

    assign iaddr     = pc_q;
    assign out_pc    = ent_pc_q[head_q];
    assign out_instr = ent_instr_q[head_q];
    assign fault     = (state_q == ST_FAULT);

endmodule
